// File: rtl/hazard_sequencer_pkg.sv
// Shared types for the MIPS pipeline hazard sequencer: state encoding,
// register-number width and the bundle of pipeline control strobes.
package hazard_sequencer_pkg;

    localparam int unsigned REG_W = 5;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_RUN     = 3'd1,
        ST_MEMWAIT = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_HALTED  = 3'd4
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_stall;
        logic ifid_flush;
        logic idex_bubble;
        logic freeze;
        logic halted;
    } ctrl_t;

    localparam ctrl_t CTRL_DEFAULT = '{pc_write: 1'b1, default: 1'b0};

endpackage

// File: rtl/hazard_sequencer_detect.sv
// Combinational load-use and ID-stage branch operand hazard detection.
module hazard_detect
    import hazard_sequencer_pkg::*;
(
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             id_branch_i,
    input  logic             ex_mem_read_i,
    input  logic             ex_reg_write_i,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic             mem_mem_read_i,
    input  logic [REG_W-1:0] mem_rd_i,
    output logic             stall_o
);

    logic ex_rd_nz;
    logic mem_rd_nz;
    logic lu;
    logic bh;

    // Register 0 is hardwired, so a write to it never creates a dependency.
    assign ex_rd_nz  = (ex_rd_i  != '0);
    assign mem_rd_nz = (mem_rd_i != '0);

    assign lu = ex_mem_read_i && ex_rd_nz &&
                ((ex_rd_i == id_rs_i) || (id_uses_rt_i && (ex_rd_i == id_rt_i)));

    assign bh = id_branch_i &&
                ((ex_reg_write_i && ex_rd_nz &&
                  ((ex_rd_i == id_rs_i) || (ex_rd_i == id_rt_i))) ||
                 (mem_mem_read_i && mem_rd_nz &&
                  ((mem_rd_i == id_rs_i) || (mem_rd_i == id_rt_i))));

    assign stall_o = lu || bh;

endmodule

// File: rtl/hazard_sequencer.sv
// Central pipeline controller: init flush, data stalls, branch flushes,
// memory-wait freeze with timeout, halt/drain, and stall/flush counters.
module hazard_sequencer
    import hazard_sequencer_pkg::*;
#(
    parameter int unsigned INIT_CYCLES  = 2,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned MAX_WAIT     = 255,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [REG_W-1:0] IDRs,
    input  logic [REG_W-1:0] IDRt,
    input  logic             IDUsesRt,
    input  logic             IDBranch,
    input  logic             IDBranchTaken,
    input  logic             IDJump,
    input  logic             EXMemRead,
    input  logic             EXRegWrite,
    input  logic [REG_W-1:0] EXRd,
    input  logic             MEMMemRead,
    input  logic [REG_W-1:0] MEMRd,
    input  logic             MemBusy,
    input  logic             HaltReq,
    output logic             PCWrite,
    output logic             IFIDStall,
    output logic             IFIDFlush,
    output logic             IDEXBubble,
    output logic             Freeze,
    output logic             Halted,
    output logic             Timeout,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int unsigned INIT_W  = $clog2(INIT_CYCLES + 1);
    localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam int unsigned WAIT_W  = $clog2(MAX_WAIT + 1);

    state_e             state_q,     state_d;
    logic [INIT_W-1:0]  init_q,      init_d;
    logic [DRAIN_W-1:0] drain_q,     drain_d;
    logic [WAIT_W-1:0]  wait_q,      wait_d;
    logic               timeout_q,   timeout_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    ctrl_t ctrl;
    logic  run_rules;
    logic  hazard_stall;

    hazard_detect u_hazard_detect (
        .id_rs_i        (IDRs),
        .id_rt_i        (IDRt),
        .id_uses_rt_i   (IDUsesRt),
        .id_branch_i    (IDBranch),
        .ex_mem_read_i  (EXMemRead),
        .ex_reg_write_i (EXRegWrite),
        .ex_rd_i        (EXRd),
        .mem_mem_read_i (MEMMemRead),
        .mem_rd_i       (MEMRd),
        .stall_o        (hazard_stall)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_INIT;
            init_q      <= '0;
            drain_q     <= '0;
            wait_q      <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            init_q      <= init_d;
            drain_q     <= drain_d;
            wait_q      <= wait_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_d      = init_q;
        drain_d     = drain_q;
        wait_d      = wait_q;
        timeout_d   = timeout_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        ctrl        = CTRL_DEFAULT;
        run_rules   = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                ctrl.pc_write    = 1'b0;
                ctrl.ifid_flush  = 1'b1;
                ctrl.idex_bubble = 1'b1;
                if (init_q == INIT_W'(INIT_CYCLES - 1)) begin
                    state_d = ST_RUN;
                    init_d  = '0;
                end else begin
                    init_d = init_q + INIT_W'(1);
                end
            end
            ST_RUN: run_rules = 1'b1;
            ST_MEMWAIT: begin
                if (MemBusy) begin
                    ctrl.freeze     = 1'b1;
                    ctrl.pc_write   = 1'b0;
                    ctrl.ifid_stall = 1'b1;
                    if (wait_q >= WAIT_W'(MAX_WAIT)) begin
                        timeout_d = 1'b1;
                        state_d   = ST_HALTED;
                        wait_d    = '0;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end else begin
                    run_rules = 1'b1;
                    wait_d    = '0;
                end
            end
            ST_DRAIN: begin
                ctrl.pc_write = 1'b0;
                // A busy memory holds the drain in place rather than flushing.
                if (MemBusy) begin
                    ctrl.freeze     = 1'b1;
                    ctrl.ifid_stall = 1'b1;
                end else begin
                    ctrl.ifid_flush = 1'b1;
                    if (drain_q >= DRAIN_W'(DRAIN_CYCLES - 1)) begin
                        state_d = ST_HALTED;
                        drain_d = '0;
                    end else begin
                        drain_d = drain_q + DRAIN_W'(1);
                    end
                end
            end
            ST_HALTED: begin
                ctrl.pc_write   = 1'b0;
                ctrl.ifid_stall = 1'b1;
                ctrl.freeze     = 1'b1;
                ctrl.halted     = 1'b1;
            end
            default: state_d = ST_INIT;
        endcase

        if (run_rules) begin
            state_d = ST_RUN;
            if (MemBusy) begin
                ctrl.freeze     = 1'b1;
                ctrl.pc_write   = 1'b0;
                ctrl.ifid_stall = 1'b1;
                state_d         = ST_MEMWAIT;
                wait_d          = WAIT_W'(1);
            end else if (hazard_stall) begin
                ctrl.pc_write    = 1'b0;
                ctrl.ifid_stall  = 1'b1;
                ctrl.idex_bubble = 1'b1;
            end else if ((IDBranch && IDBranchTaken) || IDJump) begin
                ctrl.ifid_flush = 1'b1;
                flush_cnt_d     = flush_cnt_q + CNT_W'(1);
            end else if (HaltReq) begin
                ctrl.pc_write   = 1'b0;
                ctrl.ifid_flush = 1'b1;
                state_d         = ST_DRAIN;
                drain_d         = DRAIN_W'(1);
            end
        end

        if (ctrl.ifid_stall && ((state_q == ST_RUN) || (state_q == ST_MEMWAIT))) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    assign PCWrite    = ctrl.pc_write;
    assign IFIDStall  = ctrl.ifid_stall;
    assign IFIDFlush  = ctrl.ifid_flush;
    assign IDEXBubble = ctrl.idex_bubble;
    assign Freeze     = ctrl.freeze;
    assign Halted     = ctrl.halted;
    assign Timeout    = timeout_q;
    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Randomized scoreboard bench for hazard_sequencer against a cycle-level
// behavioural model of the pipeline control rules.
module tb_hazard_sequencer;

    localparam int unsigned INIT_CYCLES  = 2;
    localparam int unsigned DRAIN_CYCLES = 4;
    localparam int unsigned MAX_WAIT     = 6;
    localparam int unsigned CNT_W        = 32;
    localparam int          N_CYCLES     = 4000;

    typedef struct packed {
        logic        pc;
        logic        stall;
        logic        flush;
        logic        bubble;
        logic        freeze;
        logic        halted;
        logic        timeout;
        logic [31:0] sc;
        logic [31:0] fc;
    } obs_t;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [4:0] IDRs, IDRt, EXRd, MEMRd;
    logic       IDUsesRt, IDBranch, IDBranchTaken, IDJump;
    logic       EXMemRead, EXRegWrite, MEMMemRead, MemBusy, HaltReq;
    logic       PCWrite, IFIDStall, IFIDFlush, IDEXBubble, Freeze, Halted, Timeout;
    logic [CNT_W-1:0] StallCount, FlushCount;

    hazard_sequencer #(
        .INIT_CYCLES  (INIT_CYCLES),
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .MAX_WAIT     (MAX_WAIT),
        .CNT_W        (CNT_W)
    ) dut (
        .Clk (Clk), .Reset (Reset),
        .IDRs (IDRs), .IDRt (IDRt), .IDUsesRt (IDUsesRt),
        .IDBranch (IDBranch), .IDBranchTaken (IDBranchTaken), .IDJump (IDJump),
        .EXMemRead (EXMemRead), .EXRegWrite (EXRegWrite), .EXRd (EXRd),
        .MEMMemRead (MEMMemRead), .MEMRd (MEMRd),
        .MemBusy (MemBusy), .HaltReq (HaltReq),
        .PCWrite (PCWrite), .IFIDStall (IFIDStall), .IFIDFlush (IFIDFlush),
        .IDEXBubble (IDEXBubble), .Freeze (Freeze), .Halted (Halted),
        .Timeout (Timeout), .StallCount (StallCount), .FlushCount (FlushCount)
    );

    always #5 Clk = ~Clk;

    // Behavioural model: remaining init cycles, busy-run length, drain progress.
    int          m_init_left;
    int          m_busy_run;
    bit          m_draining;
    int          m_drain_done;
    bit          m_halted;
    bit          m_timeout;
    int unsigned m_sc;
    int unsigned m_fc;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    bit   stim_done = 1'b0;

    function automatic logic [4:0] pick_reg();
        int r;
        r = $urandom_range(0, 5);
        case (r)
            0:       pick_reg = 5'd0;
            1:       pick_reg = 5'd8;
            2:       pick_reg = 5'd9;
            3:       pick_reg = 5'd10;
            default: pick_reg = 5'($urandom_range(0, 31));
        endcase
    endfunction

    task automatic model_reset();
        m_init_left  = INIT_CYCLES;
        m_busy_run   = 0;
        m_draining   = 1'b0;
        m_drain_done = 0;
        m_halted     = 1'b0;
        m_timeout    = 1'b0;
        m_sc         = 0;
        m_fc         = 0;
    endtask

    function automatic bit dep(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
        dep = (d != 5'd0) && (d == a || d == b);
    endfunction

    // Expected outputs for the current cycle, then advance the model one edge.
    task automatic model_step(output obs_t e);
        bit lu, bh, hz;
        e = '0;
        e.pc      = 1'b1;
        e.timeout = m_timeout;
        e.sc      = m_sc;
        e.fc      = m_fc;
        lu = EXMemRead && dep(EXRd, IDRs, IDUsesRt ? IDRt : IDRs);
        bh = IDBranch && ((EXRegWrite && dep(EXRd, IDRs, IDRt)) ||
                          (MEMMemRead && dep(MEMRd, IDRs, IDRt)));
        hz = lu || bh;
        if (m_init_left > 0) begin
            e.pc = 0; e.flush = 1; e.bubble = 1;
            m_init_left--;
        end else if (m_halted) begin
            e.pc = 0; e.stall = 1; e.freeze = 1; e.halted = 1;
        end else if (m_draining) begin
            e.pc = 0;
            if (MemBusy) begin
                e.freeze = 1; e.stall = 1;
            end else begin
                e.flush = 1;
                m_drain_done++;
                if (m_drain_done >= DRAIN_CYCLES) begin
                    m_draining = 0;
                    m_halted   = 1;
                end
            end
        end else if (MemBusy) begin
            e.pc = 0; e.stall = 1; e.freeze = 1;
            m_sc++;
            m_busy_run++;
            if (m_busy_run > MAX_WAIT) begin
                m_timeout = 1;
                m_halted  = 1;
            end
        end else begin
            m_busy_run = 0;
            if (hz) begin
                e.pc = 0; e.stall = 1; e.bubble = 1;
                m_sc++;
            end else if ((IDBranch && IDBranchTaken) || IDJump) begin
                e.flush = 1;
                m_fc++;
            end else if (HaltReq) begin
                e.pc = 0; e.flush = 1;
                m_draining   = 1;
                m_drain_done = 1;
            end
        end
        if (Reset) model_reset();
    endtask

    // Monitor: every cycle presents a full output vector to be scored.
    always @(negedge Clk) begin
        obs_t a, e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{PCWrite, IFIDStall, IFIDFlush, IDEXBubble, Freeze, Halted,
                  Timeout, StallCount, FlushCount};
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL cyc%0d outputs: got pc%b st%b fl%b bb%b fz%b h%b to%b sc=%0d fc=%0d, want pc%b st%b fl%b bb%b fz%b h%b to%b sc=%0d fc=%0d",
                         cyc, a.pc, a.stall, a.flush, a.bubble, a.freeze, a.halted, a.timeout, a.sc, a.fc,
                         e.pc, e.stall, e.flush, e.bubble, e.freeze, e.halted, e.timeout, e.sc, e.fc);
            end
        end
    end

    initial begin
        obs_t e;
        int   busy_left = 0;
        bit   halt_hold = 0;
        int   halted_for = 0;
        Reset = 1; IDRs = 0; IDRt = 0; EXRd = 0; MEMRd = 0;
        IDUsesRt = 0; IDBranch = 0; IDBranchTaken = 0; IDJump = 0;
        EXMemRead = 0; EXRegWrite = 0; MEMMemRead = 0; MemBusy = 0; HaltReq = 0;
        repeat (2) @(posedge Clk);
        model_reset();
        for (int i = 0; i < N_CYCLES; i++) begin
            #1;
            cyc = i;
            Reset         = (i == 0) || ($urandom_range(0, 499) == 0) ||
                            (m_halted && halted_for > 3 && $urandom_range(0, 3) == 0);
            IDRs          = pick_reg();
            IDRt          = pick_reg();
            EXRd          = pick_reg();
            MEMRd         = pick_reg();
            IDUsesRt      = 1'($urandom_range(0, 1));
            IDBranch      = ($urandom_range(0, 2) == 0);
            IDBranchTaken = 1'($urandom_range(0, 1));
            IDJump        = ($urandom_range(0, 9) == 0);
            EXMemRead     = ($urandom_range(0, 3) == 0);
            EXRegWrite    = 1'($urandom_range(0, 1));
            MEMMemRead    = ($urandom_range(0, 3) == 0);
            if (busy_left == 0) begin
                if ($urandom_range(0, 59) == 0) busy_left = $urandom_range(MAX_WAIT, MAX_WAIT + 3);
                else if ($urandom_range(0, 9) == 0) busy_left = $urandom_range(1, 3);
            end
            MemBusy = (busy_left > 0);
            if (busy_left > 0) busy_left--;
            if (!halt_hold && $urandom_range(0, 79) == 0) halt_hold = 1;
            HaltReq = halt_hold;
            model_step(e);
            exp_q.push_back(e);
            if (Reset || m_halted) halt_hold = 0;
            halted_for = m_halted ? halted_for + 1 : 0;
            @(posedge Clk);
        end
        stim_done = 1;
        for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(posedge Clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain_queue: %0d entries left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
